// File: rtl/muldiv_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit: EXE-stage requests,
// the DEC hazard input, and the HI/LO/busy/stall outputs.
interface muldiv_unit_if;
   logic        start_EXE;
   logic [1:0]  op_EXE;
   logic [31:0] a_EXE;
   logic [31:0] b_EXE;
   logic        mthi_EXE;
   logic        mtlo_EXE;
   logic        flush_EXE;
   logic        use_hilo_DEC;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall_req;

   modport master (
      output start_EXE, op_EXE, a_EXE, b_EXE, mthi_EXE, mtlo_EXE, flush_EXE, use_hilo_DEC,
      input  hi, lo, busy, stall_req
   );

   modport slave (
      input  start_EXE, op_EXE, a_EXE, b_EXE, mthi_EXE, mtlo_EXE, flush_EXE, use_hilo_DEC,
      output hi, lo, busy, stall_req
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO: one bit per cycle over 32
// CALC cycles, then one FIXUP cycle applying sign and special-case rules.
module muldiv_unit (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, quotient}
   logic [31:0] opnd_q, opnd_d;   // mul: multiplicand; div: divisor
   logic [31:0] a_orig_q, a_orig_d;
   logic        is_div_q, is_div_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic        dz_q, dz_d;
   logic        ovf_q, ovf_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        signed_op_s;
   logic [31:0] abs_a_s;
   logic [31:0] abs_b_s;
   logic [32:0] sum_s;
   logic [32:0] rem_sh_s;
   logic [32:0] trial_s;
   logic [63:0] prod_s;

   // State, datapath and HI/LO registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 5'd0;
         acc_q     <= 64'd0;
         opnd_q    <= 32'd0;
         a_orig_q  <= 32'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         ovf_q     <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         a_orig_q  <= a_orig_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         ovf_q     <= ovf_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Next-state, iteration step and result fix-up.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      a_orig_d  = a_orig_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      ovf_d     = ovf_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      signed_op_s = ~bus.op_EXE[0];
      abs_a_s  = (signed_op_s && bus.a_EXE[31]) ? (32'd0 - bus.a_EXE) : bus.a_EXE;
      abs_b_s  = (signed_op_s && bus.b_EXE[31]) ? (32'd0 - bus.b_EXE) : bus.b_EXE;
      sum_s    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
      rem_sh_s = {acc_q[63:32], acc_q[31]};
      trial_s  = rem_sh_s - {1'b0, opnd_q};
      prod_s   = neg_res_q ? (64'd0 - acc_q) : acc_q;

      case (state_q)
         IDLE: begin
            if (bus.start_EXE && !bus.flush_EXE) begin
               state_d   = CALC;
               cnt_d     = 5'd0;
               is_div_d  = bus.op_EXE[1];
               neg_res_d = signed_op_s & (bus.a_EXE[31] ^ bus.b_EXE[31]);
               neg_rem_d = signed_op_s & bus.a_EXE[31];
               dz_d      = bus.op_EXE[1] & (bus.b_EXE == 32'd0);
               ovf_d     = (bus.op_EXE == 2'b10) && (bus.a_EXE == 32'h8000_0000) &&
                           (bus.b_EXE == 32'hFFFF_FFFF);
               a_orig_d  = bus.a_EXE;
               if (bus.op_EXE[1]) begin
                  acc_d  = {32'd0, abs_a_s};
                  opnd_d = abs_b_s;
               end else begin
                  acc_d  = {32'd0, abs_b_s};
                  opnd_d = abs_a_s;
               end
            end else if (!bus.flush_EXE) begin
               if (bus.mthi_EXE) begin
                  hi_d = bus.a_EXE;
               end else begin
                  hi_d = hi_q;
               end
               if (bus.mtlo_EXE) begin
                  lo_d = bus.a_EXE;
               end else begin
                  lo_d = lo_q;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            cnt_d = cnt_q + 5'd1;
            if (is_div_q) begin
               if (!trial_s[32]) begin
                  acc_d = {trial_s[31:0], acc_q[30:0], 1'b1};
               end else begin
                  acc_d = {rem_sh_s[31:0], acc_q[30:0], 1'b0};
               end
            end else begin
               acc_d = {sum_s, acc_q[31:1]};
            end
            if (cnt_q == 5'd31) begin
               state_d = FIXUP;
            end else begin
               state_d = CALC;
            end
         end
         FIXUP: begin
            state_d = IDLE;
            if (is_div_q) begin
               if (dz_q) begin
                  lo_d = 32'hFFFF_FFFF;
                  hi_d = a_orig_q;
               end else if (ovf_q) begin
                  lo_d = 32'h8000_0000;
                  hi_d = 32'd0;
               end else begin
                  lo_d = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
                  hi_d = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
               end
            end else begin
               hi_d = prod_s[63:32];
               lo_d = prod_s[31:0];
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.stall_req = (state_q != IDLE) && bus.use_hilo_DEC;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_muldiv_unit;
   logic clk;
   logic reset;
   int   compared;
   int   mismatched;
   logic [31:0] exp_hi, exp_lo;

   muldiv_unit_if bus ();
   muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference results from plain signed/unsigned arithmetic.
   task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      h = 32'd0;
      l = 32'd0;
      case (op)
         2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
         2'b01: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
         2'b10: begin
            if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = 32'd0; l = 32'h8000_0000; end
            else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
         end
         default: begin
            if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
            else begin l = a / b; h = a % b; end
         end
      endcase
   endtask

   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic mtlo_too, input int flush_at);
      int n;
      int unstable;
      logic [31:0] h0, l0;
      @(negedge clk);
      h0 = bus.hi;
      l0 = bus.lo;
      bus.start_EXE = 1'b1;
      bus.op_EXE    = op;
      bus.a_EXE     = a;
      bus.b_EXE     = b;
      bus.mtlo_EXE  = mtlo_too;
      @(negedge clk);
      bus.start_EXE = 1'b0;
      bus.mtlo_EXE  = 1'b0;
      bus.a_EXE     = $urandom;
      bus.b_EXE     = $urandom;
      model(op, a, b, exp_hi, exp_lo);
      n = 0;
      unstable = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         if (bus.hi !== h0 || bus.lo !== l0) unstable++;
         check({tag, "_stall"}, {31'd0, bus.stall_req}, {31'd0, bus.use_hilo_DEC});
         bus.flush_EXE = (n == flush_at);
         n++;
         @(negedge clk);
      end
      bus.flush_EXE = 1'b0;
      check({tag, "_busy_cycles"}, n, 32'd33);
      check({tag, "_hilo_stable"}, unstable, 32'd0);
      check({tag, "_hi"}, bus.hi, exp_hi);
      check({tag, "_lo"}, bus.lo, exp_lo);
      check({tag, "_stall_after"}, {31'd0, bus.stall_req}, 32'd0);
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      compared = 0;
      mismatched = 0;
      reset = 1'b1;
      bus.start_EXE = 1'b0;
      bus.op_EXE = 2'b00;
      bus.a_EXE = 32'd0;
      bus.b_EXE = 32'd0;
      bus.mthi_EXE = 1'b0;
      bus.mtlo_EXE = 1'b0;
      bus.flush_EXE = 1'b0;
      bus.use_hilo_DEC = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      reset = 1'b0;

      do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
      check("multu_max_hi_const", bus.hi, 32'hFFFF_FFFE);
      check("multu_max_lo_const", bus.lo, 32'h0000_0001);
      do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, -1);
      check("mult_neg_lo_const", bus.lo, 32'hFFFF_FFF1);
      do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
      check("div_neg_lo_const", bus.lo, 32'hFFFF_FFFD);
      do_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0, 1'b0, -1);
      do_op("div_zero", 2'b10, 32'hFFFF_0001, 32'd0, 1'b0, -1);
      do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);

      // Stall tracking while a DIVU is in flight, and none while idle.
      bus.use_hilo_DEC = 1'b1;
      @(negedge clk);
      check("idle_stall", {31'd0, bus.stall_req}, 32'd0);
      do_op("divu_stall", 2'b11, 32'd1000, 32'd7, 1'b0, -1);
      bus.use_hilo_DEC = 1'b0;

      // Flushed start and flushed MTHI are both dropped.
      @(negedge clk);
      bus.start_EXE = 1'b1;
      bus.mthi_EXE = 1'b1;
      bus.flush_EXE = 1'b1;
      bus.op_EXE = 2'b11;
      bus.a_EXE = 32'h5555_0000;
      bus.b_EXE = 32'd3;
      @(negedge clk);
      bus.start_EXE = 1'b0;
      bus.mthi_EXE = 1'b0;
      bus.flush_EXE = 1'b0;
      check("flush_busy", {31'd0, bus.busy}, 32'd0);
      check("flush_hi", bus.hi, exp_hi);
      check("flush_lo", bus.lo, exp_lo);

      do_op("mult_flush_mid", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 5);
      do_op("start_wins", 2'b01, 32'd12345, 32'd678, 1'b1, -1);

      // MTHI then MTLO, one edge each.
      @(negedge clk);
      bus.mthi_EXE = 1'b1;
      bus.a_EXE = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.mthi_EXE = 1'b0;
      check("mthi", bus.hi, 32'hDEAD_BEEF);
      check("mthi_lo_kept", bus.lo, exp_lo);
      exp_hi = 32'hDEAD_BEEF;

      for (int i = 0; i < 10; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) ra = 32'd0 - 32'($urandom_range(0, 100));
         do_op($sformatf("rnd%0d", i), rop, ra, rb, 1'b0, -1);
      end

      // Reset mid-CALC at counter 10, then an MTLO.
      do_op("pre_reset", 2'b01, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0, -1);
      @(negedge clk);
      bus.use_hilo_DEC = 1'b1;
      bus.start_EXE = 1'b1;
      bus.op_EXE = 2'b00;
      bus.a_EXE = 32'h0F0F_0F0F;
      bus.b_EXE = 32'h7777_7777;
      @(negedge clk);
      bus.start_EXE = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("mid_rst_stall", {31'd0, bus.stall_req}, 32'd0);
      check("mid_rst_hi", bus.hi, 32'd0);
      check("mid_rst_lo", bus.lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.use_hilo_DEC = 1'b0;
      bus.mtlo_EXE = 1'b1;
      bus.a_EXE = 32'h0000_ABCD;
      @(negedge clk);
      bus.mtlo_EXE = 1'b0;
      check("mtlo_after_rst", bus.lo, 32'h0000_ABCD);
      check("mtlo_hi_zero", bus.hi, 32'd0);
      repeat (40) @(negedge clk);
      check("no_resume_lo", bus.lo, 32'h0000_ABCD);
      check("no_resume_busy", {31'd0, bus.busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
